multi_debouncer: RTL and testbench

Multi-channel, parametrised successor to the single-channel push-button debouncer. Each channel has:
- an input synchroniser;
- a saturating hysteresis counter that sets and holds a clean level;
- one-cycle press and release pulses;
- an optional auto-repeat of the press pulse while a button is held.

It sits between the board push-buttons and the stopwatch control FSM, replacing per-button debouncer instances.

---
 rtl/multi_debouncer_pkg.sv | 15 +
 rtl/debounce_channel.sv | 117 +++++++++++
 rtl/multi_debouncer.sv | 39 +++
 tb/tb_multi_debouncer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_debouncer_pkg.sv
// Shared defaults and level-state encoding for the multi-channel push-button debouncer.
package multi_debouncer_pkg;

    localparam int unsigned DefCounterBits = 7;
    localparam int unsigned DefSyncStages  = 2;
    localparam int unsigned DefRepeatBits  = 16;
    localparam int unsigned DefRepeatDelay = 50000;
    localparam int unsigned DefRepeatPeriod = 10000;

    typedef enum logic {
        StIdle = 1'b0,
        StHeld = 1'b1
    } level_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchroniser, saturating hysteresis counter, level FSM and
// auto-repeat hold timer.
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned COUNTER_BITS  = DefCounterBits,
    parameter int unsigned SYNC_STAGES   = DefSyncStages,
    parameter int unsigned REPEAT_BITS   = DefRepeatBits,
    parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [COUNTER_BITS-1:0] CntMax     = {COUNTER_BITS{1'b1}};
    localparam logic [REPEAT_BITS-1:0]  DelayLast  = REPEAT_BITS'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_BITS-1:0]  PeriodLast = REPEAT_BITS'(REPEAT_PERIOD - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (REPEAT_DELAY < 2 || 64'(REPEAT_DELAY) >= (64'(1) << REPEAT_BITS)) begin : g_bad_delay
        $error("REPEAT_DELAY must be in 2..2**REPEAT_BITS-1");
    end
    if (REPEAT_PERIOD < 2 || 64'(REPEAT_PERIOD) >= (64'(1) << REPEAT_BITS)) begin : g_bad_period
        $error("REPEAT_PERIOD must be in 2..2**REPEAT_BITS-1");
    end

    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic [REPEAT_BITS-1:0]  timer_q, timer_d;
    level_state_e            state_q, state_d;
    logic                    press_q, press_d;
    logic                    release_q, release_d;
    logic                    first_q, first_d;
    logic                    sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d     = cnt_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        timer_d   = timer_q;
        first_d   = first_q;

        if (sync_s && cnt_q != CntMax) begin
            cnt_d = cnt_q + COUNTER_BITS'(1);
        end else if (!sync_s && cnt_q != '0) begin
            cnt_d = cnt_q - COUNTER_BITS'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (cnt_q == CntMax) begin
                    state_d = StHeld;
                    press_d = 1'b1;
                    timer_d = '0;
                    first_d = 1'b1;
                end else if (!repeat_en) begin
                    timer_d = '0;
                    first_d = 1'b1;
                end
            end
            StHeld: begin
                // Leaving HELD takes priority, so a due repeat never meets a release.
                if (cnt_q == '0) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                    timer_d   = '0;
                end else if (!repeat_en) begin
                    timer_d = '0;
                    first_d = 1'b1;
                end else if (timer_q == (first_q ? DelayLast : PeriodLast)) begin
                    press_d = 1'b1;
                    timer_d = '0;
                    first_d = 1'b0;
                end else begin
                    timer_d = timer_q + REPEAT_BITS'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            state_q   <= StIdle;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            timer_q   <= '0;
            first_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            timer_q   <= timer_d;
            first_q   <= first_d;
        end
    end

    assign level         = (state_q == StHeld);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: CHANNELS independent copies of debounce_channel.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned COUNTER_BITS  = DefCounterBits,
    parameter int unsigned SYNC_STAGES   = DefSyncStages,
    parameter int unsigned REPEAT_BITS   = DefRepeatBits,
    parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        debounce_channel #(
            .COUNTER_BITS  (COUNTER_BITS),
            .SYNC_STAGES   (SYNC_STAGES),
            .REPEAT_BITS   (REPEAT_BITS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .din           (din[ch]),
            .repeat_en     (repeat_en[ch]),
            .level         (level[ch]),
            .press_pulse   (press_pulse[ch]),
            .release_pulse (release_pulse[ch])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: directed scenarios plus randomized bouncing inputs
// checked against an arithmetic reference model.
module tb_multi_debouncer;

    localparam int CH  = 4;
    localparam int CB  = 3;
    localparam int SS  = 2;
    localparam int RB  = 8;
    localparam int RD  = 8;
    localparam int RP  = 4;
    localparam int MAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] repeat_en = '0;
    logic [CH-1:0] level, press_pulse, release_pulse;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS      (CH),
        .COUNTER_BITS  (CB),
        .SYNC_STAGES   (SS),
        .REPEAT_BITS   (RB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din           (din),
        .repeat_en     (repeat_en),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: raw input history, counter value, level, enabled-hold run length.
    logic [CH-1:0] din_hist[$];
    int            cnt_m[CH];
    bit            lvl_m[CH];
    int            run_m[CH];
    logic [11:0]   exp_q[$];

    int edge_cnt = 0;
    int last_press[CH];
    int last_rel[CH];
    int npress[CH];
    int nrel[CH];
    int rep_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        din_hist.delete();
        for (int i = 0; i < SS; i++) din_hist.push_back('0);
        for (int c = 0; c < CH; c++) begin
            cnt_m[c] = 0;
            lvl_m[c] = 1'b0;
            run_m[c] = 0;
        end
    endfunction

    function automatic logic [11:0] model_edge(input logic [CH-1:0] d, input logic [CH-1:0] re);
        logic [CH-1:0] s, l, p, r;
        s = din_hist.pop_front();
        din_hist.push_back(d);
        p = '0;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            if (!lvl_m[c] && cnt_m[c] == MAX) begin
                lvl_m[c] = 1'b1;
                p[c]     = 1'b1;
                run_m[c] = 0;
            end else if (lvl_m[c] && cnt_m[c] == 0) begin
                lvl_m[c] = 1'b0;
                r[c]     = 1'b1;
                run_m[c] = 0;
            end else if (lvl_m[c] && re[c]) begin
                run_m[c]++;
                if (run_m[c] == RD || (run_m[c] > RD && (run_m[c] - RD) % RP == 0)) p[c] = 1'b1;
            end else begin
                run_m[c] = 0;
            end
            if (s[c]) cnt_m[c] = (cnt_m[c] < MAX) ? cnt_m[c] + 1 : MAX;
            else      cnt_m[c] = (cnt_m[c] > 0) ? cnt_m[c] - 1 : 0;
            l[c] = lvl_m[c];
        end
        return {l, p, r};
    endfunction

    // One clock of stimulus; returns just after the edge once the monitor has sampled.
    task automatic step(input logic [CH-1:0] d, input logic [CH-1:0] re);
        @(negedge clk);
        din       = d;
        repeat_en = re;
        exp_q.push_back(model_edge(d, re));
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int n, input logic [CH-1:0] d, input logic [CH-1:0] re);
        repeat (n) step(d, re);
    endtask

    // Monitor: pops one expected vector per edge and records pulse timing.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            if (rst_n && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("level", 32'(level), 32'(e[11:8]));
                check("press_pulse", 32'(press_pulse), 32'(e[7:4]));
                check("release_pulse", 32'(release_pulse), 32'(e[3:0]));
                for (int c = 0; c < CH; c++) begin
                    if (press_pulse[c]) begin
                        last_press[c] = edge_cnt;
                        npress[c]++;
                        if (c == 2) rep_log.push_back(edge_cnt);
                    end
                    if (release_pulse[c]) begin
                        last_rel[c] = edge_cnt;
                        nrel[c]++;
                    end
                end
            end
        end
    end

    initial begin
        int s, p0;
        int rep_a[4] = '{10, 18, 22, 26};
        int rep_b[3] = '{10, 18, 29};
        int left[CH];
        logic [CH-1:0] rd, rr;

        for (int c = 0; c < CH; c++) begin
            last_press[c] = 0; last_rel[c] = 0; npress[c] = 0; nrel[c] = 0;
        end
        model_reset();
        #1;
        check("reset_level", 32'(level), 0);
        check("reset_press", 32'(press_pulse), 0);
        check("reset_release", 32'(release_pulse), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Clean press on channel 0
        s = edge_cnt; p0 = npress[0];
        hold(12, 4'b0001, 4'b0000);
        check("clean_press_latency", 32'(last_press[0] - s), 10);
        check("clean_press_count", 32'(npress[0] - p0), 1);
        hold(20, 4'b0000, 4'b0000);

        // Bounce on channel 1, then steady
        p0 = npress[1];
        for (int i = 0; i < 40; i++) step((i % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0000);
        check("bounce_no_press", 32'(npress[1] - p0), 0);
        s = edge_cnt;
        hold(12, 4'b0010, 4'b0000);
        check("bounce_then_press_latency", 32'(last_press[1] - s), 10);

        // Release with a single glitch
        s = edge_cnt; p0 = nrel[1];
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0010, 4'b0000);
        hold(12, 4'b0000, 4'b0000);
        check("glitch_release_latency", 32'(last_rel[1] - s), 12);
        check("glitch_release_count", 32'(nrel[1] - p0), 1);
        hold(5, 4'b0000, 4'b0000);

        // Auto-repeat on channel 2
        s = edge_cnt;
        rep_log.delete();
        hold(27, 4'b0100, 4'b0100);
        check("repeat_a_count", 32'(rep_log.size()), 4);
        for (int i = 0; i < 4 && i < rep_log.size(); i++)
            check("repeat_a_edge", 32'(rep_log[i] - s), 32'(rep_a[i]));
        hold(20, 4'b0000, 4'b0000);

        // Auto-repeat with repeat_en dropped for one edge
        s = edge_cnt;
        rep_log.delete();
        for (int k = 1; k <= 30; k++) step(4'b0100, (k == 21) ? 4'b0000 : 4'b0100);
        check("repeat_b_count", 32'(rep_log.size()), 3);
        for (int i = 0; i < 3 && i < rep_log.size(); i++)
            check("repeat_b_edge", 32'(rep_log[i] - s), 32'(rep_b[i]));
        hold(20, 4'b0000, 4'b0000);

        // Asynchronous reset while channel 3 is held
        hold(12, 4'b1000, 4'b0000);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_level", 32'(level), 0);
        check("async_reset_press", 32'(press_pulse), 0);
        check("async_reset_release", 32'(release_pulse), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        s = edge_cnt;
        hold(12, 4'b1000, 4'b0000);
        check("requalify_latency", 32'(last_press[3] - s), 10);
        hold(20, 4'b0000, 4'b0000);

        // Simultaneous press, staggered release
        s = edge_cnt;
        hold(12, 4'b1111, 4'b0000);
        for (int c = 0; c < CH; c++) check("simul_press_latency", 32'(last_press[c] - s), 10);
        p0 = nrel[0] + nrel[1] + nrel[2] + nrel[3];
        hold(3, 4'b1110, 4'b0000);
        hold(3, 4'b1100, 4'b0000);
        hold(3, 4'b1000, 4'b0000);
        hold(20, 4'b0000, 4'b0000);
        check("staggered_release_count", 32'(nrel[0] + nrel[1] + nrel[2] + nrel[3] - p0), 4);

        // Randomized bouncing buttons with occasional repeat_en changes
        rd = '0;
        rr = '0;
        for (int c = 0; c < CH; c++) left[c] = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                left[c]--;
                if (left[c] == 0) begin
                    rd[c]   = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 40));
                end
                if ($urandom_range(0, 60) == 0) rr[c] = ~rr[c];
            end
            step(rd, rr);
        end
        hold(3, 4'b0000, 4'b0000);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
